// File: rtl/pzvip_tilelink_a_channel_arbiter.sv
// Round-robin, burst-locked arbiter merging several TileLink A-channel masters onto one port.
// Optional stall watchdog enabled by defining PZVIP_TILELINK_A_ARBITER_LOCK_TIMEOUT_EN.
module pzvip_tilelink_a_channel_arbiter #(
  parameter int unsigned REQUESTERS    = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH    = 3,
  parameter int unsigned SOURCE_WIDTH  = 8,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [REQUESTERS-1:0]                 i_a_valid,
  output logic [REQUESTERS-1:0]                 o_a_ready,
  input  logic [3*REQUESTERS-1:0]               i_a_opcode,
  input  logic [3*REQUESTERS-1:0]               i_a_param,
  input  logic [SIZE_WIDTH*REQUESTERS-1:0]      i_a_size,
  input  logic [SOURCE_WIDTH*REQUESTERS-1:0]    i_a_source,
  input  logic [ADDRESS_WIDTH*REQUESTERS-1:0]   i_a_address,
  input  logic [DATA_WIDTH/8*REQUESTERS-1:0]    i_a_mask,
  input  logic [DATA_WIDTH*REQUESTERS-1:0]      i_a_data,
  input  logic [REQUESTERS-1:0]                 i_a_corrupt,
  output logic                                  o_a_valid,
  input  logic                                  i_a_ready,
  output logic [2:0]                            o_a_opcode,
  output logic [2:0]                            o_a_param,
  output logic [SIZE_WIDTH-1:0]                 o_a_size,
  output logic [SOURCE_WIDTH-1:0]               o_a_source,
  output logic [ADDRESS_WIDTH-1:0]              o_a_address,
  output logic [DATA_WIDTH/8-1:0]               o_a_mask,
  output logic [DATA_WIDTH-1:0]                 o_a_data,
  output logic                                  o_a_corrupt,
  output logic [REQUESTERS-1:0]                 o_grant,
  output logic                                  o_lock_timeout
);

  localparam int unsigned MaskW    = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned LogBytes = $clog2(MaskW);
  // Beat count never exceeds 2^(2^SIZE_WIDTH-1), which fits in 2^SIZE_WIDTH bits.
  localparam int unsigned CntW     = 2 ** SIZE_WIDTH;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic                    first_beat_q, first_beat_d;
  logic [CntW-1:0]         remain_q, remain_d;

  logic [IdxW-1:0]         gidx;
  logic [IdxW-1:0]         nxt_ptr;
  logic [CntW-1:0]         beats;
  logic [REQUESTERS-1:0]   rearb_req;
  logic [REQUESTERS-1:0]   rearb_grant;
  logic                    handshake;
  logic                    last_beat;

  function automatic logic [REQUESTERS-1:0] pick(input logic [REQUESTERS-1:0] req,
                                                  input logic [IdxW-1:0]       ptr);
    logic [REQUESTERS-1:0] g;
    logic                  found;
    int unsigned           idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      idx = (32'(ptr) + i) % REQUESTERS;
      if (!found && req[IdxW'(idx)]) begin
        g[IdxW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
    return g;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      ptr_q        <= '0;
      first_beat_q <= 1'b1;
      remain_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      first_beat_q <= first_beat_d;
      remain_q     <= remain_d;
    end
  end

  // Output path: a zero grant in idle makes every output read 0.
  always_comb begin
    o_a_opcode  = '0;
    o_a_param   = '0;
    o_a_size    = '0;
    o_a_source  = '0;
    o_a_address = '0;
    o_a_mask    = '0;
    o_a_data    = '0;
    o_a_corrupt = 1'b0;
    gidx        = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (grant_q[k]) begin
        o_a_opcode  = i_a_opcode[3*k +: 3];
        o_a_param   = i_a_param[3*k +: 3];
        o_a_size    = i_a_size[SIZE_WIDTH*k +: SIZE_WIDTH];
        o_a_source  = i_a_source[SOURCE_WIDTH*k +: SOURCE_WIDTH];
        o_a_address = i_a_address[ADDRESS_WIDTH*k +: ADDRESS_WIDTH];
        o_a_mask    = i_a_mask[MaskW*k +: MaskW];
        o_a_data    = i_a_data[DATA_WIDTH*k +: DATA_WIDTH];
        o_a_corrupt = i_a_corrupt[k];
        gidx        = IdxW'(k);
      end
    end
    o_a_valid = |(i_a_valid & grant_q);
    o_a_ready = grant_q & {REQUESTERS{i_a_ready}};
    o_grant   = grant_q;
  end

  always_comb begin
    beats = CntW'(1);
    if (o_a_opcode <= 3'd3 && o_a_size > SIZE_WIDTH'(LogBytes)) begin
      beats = CntW'(1) << (o_a_size - SIZE_WIDTH'(LogBytes));
    end
  end

  assign handshake = o_a_valid & i_a_ready;
  assign last_beat = handshake &
                     (first_beat_q ? (beats == CntW'(1)) : (remain_q == CntW'(1)));
  assign nxt_ptr   = (32'(gidx) == REQUESTERS - 1) ? '0 : gidx + 1'b1;

  always_comb begin
    rearb_req = i_a_valid & ~grant_q;
    if (rearb_req == '0) begin
      rearb_req = i_a_valid;
    end
    rearb_grant = pick(rearb_req, nxt_ptr);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    first_beat_d = first_beat_q;
    remain_d     = remain_q;
    unique case (state_q)
      StIdle: begin
        if (|i_a_valid) begin
          grant_d      = pick(i_a_valid, ptr_q);
          state_d      = StActive;
          first_beat_d = 1'b1;
        end
      end
      StActive: begin
        if (handshake) begin
          if (first_beat_q) begin
            remain_d     = beats - 1'b1;
            first_beat_d = 1'b0;
          end else begin
            remain_d = remain_q - 1'b1;
          end
        end
        if (last_beat) begin
          ptr_d        = nxt_ptr;
          grant_d      = rearb_grant;
          first_beat_d = 1'b1;
          remain_d     = '0;
          if (rearb_grant == '0) begin
            state_d = StIdle;
          end
        end else if (first_beat_q && !o_a_valid) begin
          // A requester re-granted only because its final beat was the sole request
          // has nothing further to send; drop the stale grant between messages.
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef PZVIP_TILELINK_A_ARBITER_LOCK_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    if (state_q != StActive || state_d != state_q || handshake) begin
      to_cnt_d = '0;
    end else if (!first_beat_q && !o_a_valid) begin
      if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
        to_hit   = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  assign o_lock_timeout = to_hit;
`else
  assign o_lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pzvip_tilelink_a_channel_arbiter.sv
// Self-checking bench for pzvip_tilelink_a_channel_arbiter: requester agents, expected-beat queue.
module tb_pzvip_tilelink_a_channel_arbiter;

  localparam int unsigned R  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned IW = 8;
  localparam int unsigned MW = DW / 8;
`ifdef PZVIP_TILELINK_A_ARBITER_LOCK_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic            clk;
  logic            i_rst;
  logic [R-1:0]    i_a_valid;
  logic [R-1:0]    o_a_ready;
  logic [3*R-1:0]  i_a_opcode;
  logic [3*R-1:0]  i_a_param;
  logic [SW*R-1:0] i_a_size;
  logic [IW*R-1:0] i_a_source;
  logic [AW*R-1:0] i_a_address;
  logic [MW*R-1:0] i_a_mask;
  logic [DW*R-1:0] i_a_data;
  logic [R-1:0]    i_a_corrupt;
  logic            o_a_valid;
  logic            i_a_ready;
  logic [2:0]      o_a_opcode;
  logic [2:0]      o_a_param;
  logic [SW-1:0]   o_a_size;
  logic [IW-1:0]   o_a_source;
  logic [AW-1:0]   o_a_address;
  logic [MW-1:0]   o_a_mask;
  logic [DW-1:0]   o_a_data;
  logic            o_a_corrupt;
  logic [R-1:0]    o_grant;
  logic            o_lock_timeout;

  pzvip_tilelink_a_channel_arbiter #(
    .REQUESTERS   (R),
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .SIZE_WIDTH   (SW),
    .SOURCE_WIDTH (IW),
    .TIMEOUT      (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_a_valid     (i_a_valid),
    .o_a_ready     (o_a_ready),
    .i_a_opcode    (i_a_opcode),
    .i_a_param     (i_a_param),
    .i_a_size      (i_a_size),
    .i_a_source    (i_a_source),
    .i_a_address   (i_a_address),
    .i_a_mask      (i_a_mask),
    .i_a_data      (i_a_data),
    .i_a_corrupt   (i_a_corrupt),
    .o_a_valid     (o_a_valid),
    .i_a_ready     (i_a_ready),
    .o_a_opcode    (o_a_opcode),
    .o_a_param     (o_a_param),
    .o_a_size      (o_a_size),
    .o_a_source    (o_a_source),
    .o_a_address   (o_a_address),
    .o_a_mask      (o_a_mask),
    .o_a_data      (o_a_data),
    .o_a_corrupt   (o_a_corrupt),
    .o_grant       (o_grant),
    .o_lock_timeout(o_lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] src;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] order;  // grant order, one nibble per message, first in [3:0]
    int          n;
  } row_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  int         rem  [R];
  int         beat [R];
  logic [2:0] op   [R];
  logic [2:0] sz   [R];
  logic [7:0] src  [R];
  bit         hold [R];

  function automatic logic [63:0] beat_data(int k, logic [7:0] s, int b);
    return {24'h0, 8'(k), s, 16'(b), 8'h5A};
  endfunction

  function automatic bit busy();
    for (int k = 0; k < R; k++) if (rem[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_agents();
    for (int k = 0; k < R; k++) begin
      rem[k] = 0; beat[k] = 0; op[k] = 3'd4; sz[k] = 3'd3; src[k] = 8'h0; hold[k] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < R; k++) begin
      i_a_valid[k]              = (rem[k] > 0) && !hold[k];
      i_a_opcode[3*k +: 3]      = op[k];
      i_a_param[3*k +: 3]       = 3'd0;
      i_a_size[SW*k +: SW]      = sz[k];
      i_a_source[IW*k +: IW]    = src[k];
      i_a_address[AW*k +: AW]   = 32'h1000 * k + 32'(beat[k] * 8);
      i_a_mask[MW*k +: MW]      = '1;
      i_a_data[DW*k +: DW]      = beat_data(k, src[k], beat[k]);
      i_a_corrupt[k]            = 1'b0;
    end
  endtask

  // Called at a negedge: drive this cycle's inputs, let outputs settle.
  task automatic settle();
    drive();
    #1;
  endtask

  // Score the handshake (if any) then move to the next negedge.
  task automatic advance();
    logic [R-1:0] hsv;
    exp_t         e;
    if (!i_rst && o_a_valid && i_a_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got grant %b source %0h want no beat", o_grant,
                 o_a_source);
      end else begin
        e = sbq.pop_front();
        check("beat_grant", 64'(o_grant), 64'(1 << e.idx));
        check("beat_source", 64'(o_a_source), 64'(e.src));
        check("beat_data", o_a_data, e.data);
      end
    end
    hsv = o_a_ready & i_a_valid;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < R; k++) begin
      if (hsv[k]) begin
        rem[k]--;
        beat[k]++;
      end
    end
  endtask

  task automatic start_msg(input int k, input logic [2:0] o, input logic [2:0] s,
                           input logic [7:0] id);
    op[k]   = o;
    sz[k]   = s;
    src[k]  = id;
    beat[k] = 0;
    rem[k]  = (o <= 3'd3 && s > 3'd3) ? (1 << (s - 3)) : 1;
  endtask

  task automatic push(input int k, input int first_b, input int nbeats);
    exp_t e;
    for (int b = first_b; b < first_b + nbeats; b++) begin
      e.idx  = k;
      e.src  = src[k];
      e.data = beat_data(k, src[k], b);
      sbq.push_back(e);
    end
  endtask

  task automatic run_until_done(input int max, output int cycles);
    cycles = 0;
    while (busy() && cycles < max) begin
      settle();
      advance();
      cycles++;
    end
    if (busy()) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got requests still pending after %0d cycles want done", max);
      clear_agents();
    end
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 4; n++) begin
      settle();
      if (o_grant == '0) break;
      advance();
    end
    check(name, 64'(o_grant), 64'(0));
    check({name, "_drained"}, 64'(sbq.size()), 64'(0));
  endtask

  task automatic reset_dut();
    i_rst = 1'b1;
    settle();
    advance();
    settle();
    advance();
    i_rst = 1'b0;
    clear_agents();
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t rows[8];
    int   cycles;
    int   first;

    i_a_ready = 1'b1;
    i_rst     = 1'b1;
    clear_agents();
    @(negedge clk);
    reset_dut();

    settle();
    check("rst_valid", 64'(o_a_valid), 64'(0));
    check("rst_ready", 64'(o_a_ready), 64'(0));
    check("rst_grant", 64'(o_grant), 64'(0));
    check("rst_data", o_a_data, 64'(0));
    check("rst_timeout", 64'(o_lock_timeout), 64'(0));

    // Single-beat Gets; rows run back to back so the pointer carries across them.
    rows[0] = '{mask: 4'b1111, order: 16'h3210, n: 4};
    rows[1] = '{mask: 4'b0100, order: 16'hFFF2, n: 1};
    rows[2] = '{mask: 4'b0011, order: 16'hFF10, n: 2};
    rows[3] = '{mask: 4'b1001, order: 16'hFF03, n: 2};
    rows[4] = '{mask: 4'b0101, order: 16'hFF02, n: 2};
    rows[5] = '{mask: 4'b0010, order: 16'hFFF1, n: 1};
    rows[6] = '{mask: 4'b1010, order: 16'hFF13, n: 2};
    rows[7] = '{mask: 4'b1100, order: 16'hFF32, n: 2};

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < R; k++) begin
        if (rows[r].mask[k]) start_msg(k, 3'd4, 3'd3, 8'(r * 16 + k));
      end
      for (int j = 0; j < rows[r].n; j++) push(int'(rows[r].order[4*j +: 4]), 0, 1);
      first = int'(rows[r].order[3:0]);
      settle();
      check("row_latency", 64'(o_a_valid), 64'(0));
      advance();
      settle();
      check("row_first_grant", 64'(o_grant), 64'(1 << first));
      advance();
      run_until_done(20, cycles);
      check("row_cycles", 64'(cycles + 2), 64'(rows[r].n + 1));
      wait_idle("row_idle");
    end

    // Burst lock: pointer 1, req1 4-beat PutFull contends with req0 Get.
    reset_dut();
    start_msg(0, 3'd4, 3'd3, 8'h30);
    push(0, 0, 1);
    run_until_done(10, cycles);
    wait_idle("lock_pre_idle");
    start_msg(1, 3'd0, 3'd5, 8'h41);
    push(1, 0, 4);
    start_msg(0, 3'd4, 3'd3, 8'h40);
    push(0, 0, 1);
    run_until_done(20, cycles);
    check("lock_cycles", 64'(cycles), 64'(6));
    wait_idle("lock_idle");

    // Backpressure: payload held stable for 5 stalled cycles.
    i_a_ready = 1'b0;
    start_msg(0, 3'd4, 3'd3, 8'h52);
    push(0, 0, 1);
    settle();
    advance();
    for (int s = 0; s < 5; s++) begin
      settle();
      check("bp_valid", 64'(o_a_valid), 64'(1));
      check("bp_source", 64'(o_a_source), 64'(8'h52));
      check("bp_data", o_a_data, beat_data(0, 8'h52, 0));
      check("bp_ready", 64'(o_a_ready), 64'(0));
      advance();
    end
    i_a_ready = 1'b1;
    settle();
    check("bp_release_ready", 64'(o_a_ready), 64'(4'b0001));
    advance();
    wait_idle("bp_idle");

    // Reset during beat 2 of a 4-beat Put abandons it and resets the pointer.
    start_msg(2, 3'd0, 3'd5, 8'h62);
    push(2, 0, 1);
    settle();
    advance();
    settle();
    advance();
    i_rst = 1'b1;
    settle();
    advance();
    i_rst = 1'b0;
    clear_agents();
    settle();
    check("midrst_valid", 64'(o_a_valid), 64'(0));
    check("midrst_grant", 64'(o_grant), 64'(0));
    check("midrst_ready", 64'(o_a_ready), 64'(0));
    start_msg(0, 3'd4, 3'd3, 8'h80);
    start_msg(3, 3'd4, 3'd3, 8'h83);
    push(0, 0, 1);
    push(3, 0, 1);
    run_until_done(10, cycles);
    wait_idle("midrst_idle");

    // Mid-burst stall: lock held against req0, watchdog pulses on the 8th stall cycle.
    start_msg(3, 3'd0, 3'd4, 8'h73);
    push(3, 0, 2);
    settle();
    advance();
    settle();
    advance();
    hold[3] = 1'b1;
    start_msg(0, 3'd4, 3'd3, 8'h70);
    push(0, 0, 1);
    for (int s = 1; s <= 8; s++) begin
      settle();
      check("stall_timeout", 64'(o_lock_timeout), 64'(TimeoutEn && s == 8));
      check("stall_grant", 64'(o_grant), 64'(4'b1000));
      advance();
    end
    hold[3] = 1'b0;
    run_until_done(10, cycles);
    wait_idle("stall_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pzvip_tilelink_a_channel_arbiter.md
Name: pzvip_tilelink_a_channel_arbiter

Overview:
- Round-robin arbiter that merges REQUESTERS TileLink A-channel masters onto one A-channel slave port.
- Multi-beat messages (PutFullData, PutPartialData, ArithmeticData, LogicalData) are burst-locked, so beats from different requesters never interleave.
- Used by the TileLink VIP/testbench fabric as the A-side crossbar front end, ahead of a single slave agent or DUT.

Parameters:
REQUESTERS, 4, number of upstream A-channel masters (>=2)
DATA_WIDTH, 64, A-channel data width in bits (power of 2, >=8)
ADDRESS_WIDTH, 32, address width
SIZE_WIDTH, 3, width of the size field (log2 bytes)
SOURCE_WIDTH, 8, source ID width
TIMEOUT, 256, stall cycles mid-burst before o_lock_timeout pulses (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_a_valid  in  REQUESTERS  per-requester valid
o_a_ready  out  REQUESTERS  per-requester ready
i_a_opcode  in  3*REQUESTERS  packed A opcodes (PutFull=0, PutPartial=1, Arith=2, Logic=3, Get=4, Hint=5, AcqBlock=6, AcqPerm=7)
i_a_param  in  3*REQUESTERS  packed param
i_a_size  in  SIZE_WIDTH*REQUESTERS  packed log2 size
i_a_source  in  SOURCE_WIDTH*REQUESTERS  packed source
i_a_address  in  ADDRESS_WIDTH*REQUESTERS  packed address
i_a_mask  in  DATA_WIDTH/8*REQUESTERS  packed mask
i_a_data  in  DATA_WIDTH*REQUESTERS  packed data
i_a_corrupt  in  REQUESTERS  packed corrupt
o_a_valid  out  1  merged valid
i_a_ready  in  1  downstream ready
o_a_opcode / o_a_param / o_a_size / o_a_source / o_a_address / o_a_mask / o_a_data / o_a_corrupt  out  3/3/SIZE_WIDTH/SOURCE_WIDTH/ADDRESS_WIDTH/DATA_WIDTH/8/DATA_WIDTH/1  payload of the granted requester
o_grant  out  REQUESTERS  registered one-hot grant (0 when idle)
o_lock_timeout  out  1  one-cycle stall-timeout pulse

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high. Reset drives state=IDLE, grant=0, pointer=0, beat counter=0, first_beat=1, timeout counter=0. All outputs read 0 from the first cycle after reset.
- Reset mid-burst abandons the burst; no completion is generated.
- States: IDLE, ACTIVE.
- IDLE: if any i_a_valid is set, latch a one-hot grant to the first valid index at or above the pointer, searching modulo REQUESTERS. Go to ACTIVE with first_beat=1.
  - Latency: o_a_valid is seen 1 cycle after i_a_valid when the arbiter is idle.
- ACTIVE, output path:
  - o_a_valid = i_a_valid[grant]; payload outputs mux from the granted slice.
  - o_a_ready[k] = i_a_ready & grant[k]; all other o_a_ready bits are 0.
  - In IDLE, o_a_valid=0, o_a_ready=0 and the payload outputs are 0.
- Beat count, computed from the granted payload on its first beat:
  - beats = 2^size / (DATA_WIDTH/8) when opcode<=3 and 2^size > DATA_WIDTH/8.
  - beats = 1 otherwise (this includes every Get, Hint and Acquire).
  - Counter width is sized for the maximum 2^(2^SIZE_WIDTH-1) bytes.
- Handshake = o_a_valid & i_a_ready.
  - On a first-beat handshake: load remaining = beats-1 and clear first_beat.
  - On each later handshake: decrement remaining.
- Last beat = handshake with (first_beat & beats==1) or (!first_beat & remaining==1). On the last beat:
  - pointer = granted index+1, wrapping to 0.
  - Re-arbitrate the same cycle among the current i_a_valid, excluding the finishing requester's bit unless it is the only one valid, using the new pointer.
  - If a winner exists: load the new grant, stay ACTIVE, set first_beat=1. This gives back-to-back messages with no bubble.
  - If no winner: go to IDLE and clear grant.
- Grant never changes mid-message or while o_a_valid is high without ready. Payload outputs are therefore stable under backpressure, as long as the requester obeys the TileLink stability rule.
- Deasserting valid mid-burst holds the lock; no other requester is granted until the burst completes.
- Width rules: size and mask are passed through unmodified; the arbiter does no source remapping.

Optional Feature:
- Macro: PZVIP_TILELINK_A_ARBITER_LOCK_TIMEOUT_EN.
- Defined:
  - The timeout counter increments each ACTIVE cycle with first_beat=0 and o_a_valid=0, i.e. the requester stalls mid-burst.
  - The counter clears on any handshake or state change.
  - When it reaches TIMEOUT: o_lock_timeout=1 for one cycle, the counter returns to 0 and keeps counting.
  - Lock is not released.
- Undefined: no counter exists and o_lock_timeout is tied to 0.

Test Plan:
- Idle, req2 Get size=3, i_a_ready=1 -> next cycle o_grant=0100, o_a_valid=1, o_a_source=req2 source; one handshake; return to IDLE; pointer=3.
- Reqs 0-3 all hold Get, ready=1, pointer=0 -> grants 0,1,2,3 on consecutive cycles with no bubble; then IDLE.
- Pointer=1, req1 PutFullData size=5 (4 beats @64b), req0 valid from cycle 0 -> 4 contiguous req1 beats; req0 granted in the cycle after beat 4.
- Req0 Get, i_a_ready=0 for 5 cycles -> o_a_valid and payload stable; o_a_ready=0 for all; handshake on cycle 6.
- Macro on, TIMEOUT=8, req3 PutFull size=4 (2 beats): beat 1 accepted, then valid low 8 cycles -> o_lock_timeout pulses on the 8th stall cycle; grant stays 1000; beat 2 completes normally.
- i_rst=1 during beat 2 of a 4-beat Put -> next cycle o_a_valid=0, o_grant=0, o_a_ready=0; after release, arbitration starts from pointer 0.
